prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_cksum.sv | 23 ++
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // The word count arrives least-significant byte first.
    localparam bit LEN_LSB_FIRST     = 1'b1;
    localparam int CKSUM_W           = 8;
    localparam int DEFAULT_MAX_WORDS = 16384;

    function automatic logic is_busy(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader_cksum.sv
// rtl/prog_loader_cksum.sv - modulo-256 byte accumulator with clear and add enable
module prog_loader_cksum
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               add_en,
    input  logic [CKSUM_W-1:0] data,
    output logic [CKSUM_W-1:0] sum
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed, checksummed image into program memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          len_first;
    logic [16:0]         bytes_left;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [CKSUM_W-1:0]  sum;
    logic [CKSUM_W-1:0]  sum_chk;
    logic [15:0]         count;
    logic                xfer;
    logic                start_ok;
    logic                data_xfer;

    // rx_ready is only ever high in a loading state, so abort is the sole extra veto.
    assign xfer      = rx_valid && rx_ready && !abort;
    assign data_xfer = xfer && (state == S_DATA);
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign count     = LEN_LSB_FIRST ? {rx_data, len_first} : {len_first, rx_data};
    assign sum_chk   = sum + rx_data;
    assign cpu_hold  = busy | mem_we;

    prog_loader_cksum u_cksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok),
        .add_en  (xfer && ((state == S_DATA) || (state == S_CHECK))),
        .data    (rx_data),
        .sum     (sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (abort)     state_nxt = S_ERROR;
                else if (xfer) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (abort) state_nxt = S_ERROR;
                else if (xfer) begin
                    if (count == 16'd0)             state_nxt = S_CHECK;
                    else if ({1'b0, count} > MAX_W) state_nxt = S_ERROR;
                    else                            state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (abort)                              state_nxt = S_ERROR;
                else if (xfer && bytes_left == 17'd1)   state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (abort)     state_nxt = S_ERROR;
                else if (xfer) state_nxt = (sum_chk == '0) ? S_DONE : S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_data   <= '0;
            mem_addr   <= '0;
            addr_cnt   <= '0;
            bytes_left <= '0;
            len_first  <= '0;
        end else begin
            state    <= state_nxt;
            rx_ready <= is_busy(state_nxt);
            busy     <= is_busy(state_nxt);
            done     <= (state_nxt == S_DONE);
            error    <= (state_nxt == S_ERROR);
            mem_we   <= data_xfer;
            if (data_xfer) begin
                mem_data   <= rx_data;
                mem_addr   <= addr_cnt;
                addr_cnt   <= addr_cnt + 1'b1;
                bytes_left <= bytes_left - 17'd1;
            end
            if (xfer && state == S_LEN_LO) len_first <= rx_data;
            if (xfer && state == S_LEN_HI) bytes_left <= {count, 1'b0};
            if (start_ok) begin
                addr_cnt   <= '0;
                bytes_left <= '0;
                len_first  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W    = 15;
    localparam int MAX_WORDS = 16384;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [7:0]        mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] fixed_q[$];
    bit         use_fixed_chk = 0;
    logic [7:0] fixed_chk;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %0h@%0h expected none", mem_data, mem_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mem_addr !== mon_e.addr || mem_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL write: got %0h@%0h expected %0h@%0h",
                                 mem_data, mem_addr, mon_e.data, mon_e.addr);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input bit with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Reference: bytes 0..2*cnt-1 land at addresses 0.., the load is good exactly
    // when the data bytes plus the check byte sum to zero modulo 256.
    task automatic run_load(input int cnt, input bit good, input bit gaps,
                            input bit start_mid, input bit skip_start);
        logic [7:0] d;
        logic [7:0] chk;
        int         sum = 0;
        bit         exp_good;
        if (!skip_start) pulse_start(1'b0);
        send_byte(cnt[7:0], gaps);
        send_byte(cnt[15:8], gaps);
        if (cnt > MAX_WORDS) begin
            wait_idle();
            check("len_err_error", error, 1);
            check("len_err_done", done, 0);
            check("len_err_nowrites", exp_q.size(), 0);
            return;
        end
        for (int k = 0; k < 2 * cnt; k++) begin
            d = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
            sum += d;
            exp_q.push_back('{addr: k[ADDR_W-1:0], data: d});
            send_byte(d, gaps);
            if (start_mid && k == 0) pulse_start(1'b0);
        end
        chk = 8'(256 - (sum % 256));
        if (use_fixed_chk)  chk = fixed_chk;
        else if (!good)     chk = chk + 8'($urandom_range(1, 255));
        exp_good = (((sum + int'(chk)) % 256) == 0);
        send_byte(chk, gaps);
        wait_idle();
        check("load_done", done, exp_good);
        check("load_error", error, !exp_good);
        check("load_busy", busy, 0);
        check("load_cpu_hold", cpu_hold, 0);
        check("load_writes_left", exp_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, {rx_ready, mem_we, busy, done, error, cpu_hold}, 6'b0);
        check({tag, "_mem"}, {mem_data, 17'(mem_addr)}, 25'b0);
    endtask

    initial begin
        #12 check_quiet("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        use_fixed_chk = 1; fixed_chk = 8'h56;
        run_load(2, 1, 0, 0, 0);
        fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fixed_chk = 8'h57;
        run_load(2, 1, 0, 0, 0);
        use_fixed_chk = 0;

        run_load(16'h4001, 1, 0, 0, 0);
        run_load(0, 1, 1, 0, 0);
        run_load(0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++)
            run_load($urandom_range(1, 8), ($urandom_range(0, 3) != 0), 1, 0, 0);

        // Abort after two data bytes with random rx_valid gaps.
        pulse_start(1'b0);
        send_byte(8'h04, 1);
        send_byte(8'h00, 1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{addr: k[ADDR_W-1:0], data: 8'(k + 8'hA0)});
            send_byte(8'(k + 8'hA0), 1);
        end
        @(negedge clk);
        abort = 1'b1;
        check("abort_busy_before", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_after", busy, 0);
        check("abort_error", error, 1);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_writes_left", exp_q.size(), 0);

        // Abort is ignored once idle in ERROR.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_idle_error", {busy, error}, 2'b01);

        // Reset mid-DATA abandons the load immediately.
        pulse_start(1'b0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{addr: k[ADDR_W-1:0], data: 8'(k + 8'h10)});
            send_byte(8'(k + 8'h10), 0);
        end
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_writes_left", exp_q.size(), 0);
        reset_n = 1'b0;
        #1 check_quiet("midload_reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_load(3, 1, 1, 0, 0);

        // start during DATA is ignored; start+abort in DONE begins a new load.
        run_load(4, 1, 0, 1, 0);
        pulse_start(1'b1);
        check("restart_busy", busy, 1);
        check("restart_flags", {done, error}, 2'b00);
        run_load(2, 1, 0, 0, 1);

        run_load(MAX_WORDS, 1, 0, 0, 0);
        run_load(MAX_WORDS + 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
